// File: rtl/packet_read_aligner_if.sv
// packet_read_aligner_if: load request, result and packet memory read port signals
interface packet_read_aligner_if #(
   parameter int ADDR_WIDTH = 10
);
   logic                  rd_en;
   logic [1:0]            transfer_sz;
   logic [ADDR_WIDTH-1:0] byte_addr;
   logic [ADDR_WIDTH:0]   pkt_len;
   logic                  busy;
   logic                  mem_rd_en;
   logic [ADDR_WIDTH-3:0] mem_addr;
   logic [31:0]           mem_rdata;
   logic [31:0]           data;
   logic                  data_valid;
   logic                  oob;
   modport slave (
      input  rd_en, transfer_sz, byte_addr, pkt_len, mem_rdata,
      output busy, mem_rd_en, mem_addr, data, data_valid, oob
   );
   modport master (
      output rd_en, transfer_sz, byte_addr, pkt_len, mem_rdata,
      input  busy, mem_rd_en, mem_addr, data, data_valid, oob
   );
endinterface

// File: rtl/packet_read_aligner.sv
// packet_read_aligner: byte-addressed BPF loads onto a 32-bit word memory; optional bounds check via PKT_RD_OOB_CHECK_EN
module packet_read_aligner #(
   parameter int ADDR_WIDTH = 10
) (
   input logic                    clk,
   input logic                    rst,
   packet_read_aligner_if.slave   bus
);
   localparam int WA = ADDR_WIDTH - 2;
   typedef enum logic {ISSUE, SECOND} state_t;
   state_t        state_q, state_d;
   logic [WA-1:0] w, w1_q, w1_d;
   logic [1:0]    o, sz;
   logic          acc, str, req_oob;
   logic          a_v_q, a_v_d, a_str_q, a_str_d, a_oob_q, a_oob_d;
   logic [1:0]    a_o_q, a_o_d, a_sz_q, a_sz_d;
   logic          b_v_q, b_v_d;
   logic [1:0]    b_o_q, b_o_d, b_sz_q, b_sz_d;
   logic [31:0]   hold_q, hold_d, data_q, data_d, up, merged;
   logic [63:0]   pair;
   logic [1:0]    m_o, m_sz;
   logic          fin, fin_oob;
   logic          dv_q, dv_d, oob_q, oob_d;
   assign w  = bus.byte_addr[ADDR_WIDTH-1:2];
   assign o  = bus.byte_addr[1:0];
   assign sz = bus.transfer_sz;
`ifdef PKT_RD_OOB_CHECK_EN
   logic [ADDR_WIDTH:0] nbytes, end_addr;
   assign nbytes   = sz == 2'b00 ? (ADDR_WIDTH+1)'(4) : sz == 2'b01 ? (ADDR_WIDTH+1)'(2) : (ADDR_WIDTH+1)'(1);
   assign end_addr = {1'b0, bus.byte_addr} + nbytes;
   assign req_oob  = end_addr > bus.pkt_len;
`else
   assign req_oob  = 1'b0;
`endif
   assign acc = state_q == ISSUE && bus.rd_en && sz != 2'b11;
   assign str = ((sz == 2'b00 && o != 2'b00) || (sz == 2'b01 && o == 2'b11)) && !req_oob;
   assign bus.busy       = state_q == SECOND;
   assign bus.mem_rd_en  = !rst && (state_q == SECOND || (acc && !req_oob));
   assign bus.mem_addr   = state_q == SECOND ? w1_q : w;
   assign bus.data       = data_q;
   assign bus.data_valid = dv_q;
   assign bus.oob        = oob_q;
   // next state, attribute pipeline, straddle hold and big-endian merge of the finishing load
   always_comb begin
      state_d = state_q == SECOND ? ISSUE : (acc && str ? SECOND : ISSUE);
      w1_d    = acc ? w + 1'b1 : w1_q;
      a_v_d   = acc;
      a_o_d   = o;
      a_sz_d  = sz;
      a_str_d = str;
      a_oob_d = req_oob;
      b_v_d   = a_v_q && a_str_q;
      b_o_d   = a_o_q;
      b_sz_d  = a_sz_q;
      hold_d  = a_v_q && a_str_q ? bus.mem_rdata : hold_q;
      pair    = b_v_q ? {hold_q, bus.mem_rdata} : {bus.mem_rdata, 32'h0};
      m_o     = b_v_q ? b_o_q : a_o_q;
      m_sz    = b_v_q ? b_sz_q : a_sz_q;
      up      = 32'((pair << {m_o, 3'b000}) >> 32);
      merged  = m_sz == 2'b00 ? up : m_sz == 2'b01 ? {16'h0, up[31:16]} : {24'h0, up[31:24]};
      fin     = b_v_q || (a_v_q && !a_str_q);
      fin_oob = !b_v_q && a_oob_q;
      data_d  = fin ? (fin_oob ? 32'h0 : merged) : data_q;
      dv_d    = fin;
      oob_d   = fin && fin_oob;
   end
   // all state; reset drops any in-flight load and clears the outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ISSUE;
         w1_q    <= '0;
         a_v_q   <= 1'b0;
         a_o_q   <= '0;
         a_sz_q  <= '0;
         a_str_q <= 1'b0;
         a_oob_q <= 1'b0;
         b_v_q   <= 1'b0;
         b_o_q   <= '0;
         b_sz_q  <= '0;
         hold_q  <= '0;
         data_q  <= '0;
         dv_q    <= 1'b0;
         oob_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         w1_q    <= w1_d;
         a_v_q   <= a_v_d;
         a_o_q   <= a_o_d;
         a_sz_q  <= a_sz_d;
         a_str_q <= a_str_d;
         a_oob_q <= a_oob_d;
         b_v_q   <= b_v_d;
         b_o_q   <= b_o_d;
         b_sz_q  <= b_sz_d;
         hold_q  <= hold_d;
         data_q  <= data_d;
         dv_q    <= dv_d;
         oob_q   <= oob_d;
      end
   end
endmodule

// File: doc/packet_read_aligner.md
# packet_read_aligner

Sits between the BPF CPU controller/datapath and the packet memory read port. It turns a byte-addressed BPF load into one or two reads of a 32-bit word-addressed memory. The load can be word, half-word or byte sized, at any alignment. The result is right-justified, zero-extended and big-endian (network order), delivered at a fixed latency with a busy stall for straddling accesses.

## Interface
Parameters:
- `ADDR_WIDTH`, 10, byte-address width; memory word address is `ADDR_WIDTH-2` bits.

Ports (name, direction, width, meaning):
- `clk`, in, 1: clock; one clock domain, everything on rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `rd_en`, in, 1: load request (controller's `packet_mem_rd_en`).
- `transfer_sz`, in, 2: 00 word, 01 half, 10 byte, 11 reserved.
- `byte_addr`, in, ADDR_WIDTH: load byte address.
- `pkt_len`, in, ADDR_WIDTH+1: packet length in bytes; must be stable while a load is in flight.
- `busy`, out, 1: request not accepted this cycle; controller stalls.
- `mem_rd_en`, out, 1: packet memory read enable.
- `mem_addr`, out, ADDR_WIDTH-2: packet memory word address.
- `mem_rdata`, in, 32: read data, valid one cycle after `mem_rd_en`; byte 0 = bits [31:24].
- `data`, out, 32: aligned, zero-extended load result.
- `data_valid`, out, 1: `data` valid this cycle (single-cycle pulse).
- `oob`, out, 1: out-of-bounds load, pulses with `data_valid`.

## Operation
- Word index `w = byte_addr[ADDR_WIDTH-1:2]`; offset `o = byte_addr[1:0]`.
- A load straddles two words when it is a word with `o != 0`, or a half with `o == 3`. Byte loads never straddle.
- States:
  - ISSUE (reset state): `busy` = 0.
    - `rd_en` with sz != 11 drives `mem_rd_en`/`mem_addr = w` combinationally in the same cycle.
    - A straddling load latches `w+1` and goes to SECOND.
  - SECOND: `busy` = 1; issues `mem_addr = w+1` and returns to ISSUE.
    - `rd_en` is ignored in SECOND; the controller must hold the request.
- `w+1` wraps modulo 2^(ADDR_WIDTH-2).
- Request attributes (o, sz, straddle, oob) travel in a 2-entry pipeline alongside the memory.
  - First-word data is captured in a hold register for straddles.
- Merge, with W0 = first word and W1 = second word:
  - word: `{W0, W1} << (8*o)`, upper 32 bits.
  - half: bytes o, o+1 → `data[15:0]`.
  - byte: byte o → `data[7:0]`.
  - All other bits are 0.
- `transfer_sz` = 11: no memory access, no `data_valid`, no state change.
- Reset (asynchronous, any time, including during SECOND):
  - state → ISSUE; pipeline valids cleared; in-flight loads dropped.
  - `busy` = 0, `mem_rd_en` = 0, `data_valid` = 0, `oob` = 0, `data` = 0.

## Timing
- Non-straddling request accepted in cycle T: memory read in T, `mem_rdata` in T+1, `data`/`data_valid` registered and visible in T+2.
- Straddling request accepted in T: second read in T+1 with `busy` high, `data_valid` in T+3.
- A new request is accepted in T+2, back-to-back behind a straddle. Results never collide.
- Non-straddling requests are accepted every cycle; throughput is 1 per cycle.
- `data` holds its last value when `data_valid` is low.

## Configuration
- `PKT_RD_OOB_CHECK_EN` defined:
  - A request with `byte_addr + nbytes > pkt_len` (nbytes 4/2/1; compare at ADDR_WIDTH+1 bits) issues no memory read and does not enter SECOND.
  - Two cycles later it produces `data_valid` = 1, `oob` = 1, `data` = 0.
- Not defined:
  - `oob` is tied 0, `pkt_len` is unused, and all loads read memory regardless of length.

## Test plan
- Aligned word at `byte_addr` = 0x008, mem word 2 = 0xDEADBEEF → `data` = 0xDEADBEEF, `data_valid` at T+2, `busy` never high.
- Word at 0x009, words 2/3 = 0x11223344/0x55667788 → `mem_addr` 2 then 3, `busy` high at T+1, `data` = 0x22334455 at T+3.
- Half at 0x00B (straddle) → 0x00004455 at T+3; half at 0x00A → 0x00003344 at T+2; byte at 0x00F → 0x00000088.
- Back-to-back byte loads at 0x008, 0x009, 0x00A on consecutive cycles → 0x11, 0x22, 0x33 on three consecutive `data_valid` cycles.
- With `PKT_RD_OOB_CHECK_EN`, `pkt_len` = 10, word at 0x007 → no `mem_rd_en`, `oob` = 1 and `data` = 0 at T+2. Same load with `pkt_len` = 11 → normal straddle.
- Assert `rst` in the SECOND cycle of a straddle → `busy`/`mem_rd_en`/`data_valid` low immediately, no stale `data_valid` afterwards. Then wrap test: word at the last address with o = 2 reads words max and 0.
